mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Arbitrates a single unified memory port between the Y86 instruction-fetch requester and the data requester.
//  Sits between the Cpu core and the memory.
//  Sequences each access IDLE -> ACCESS -> DONE and returns read data to the winning requester.
//  Prevents fetch starvation and detects a memory that never acknowledges.
// PARAMETERS
//  AW          64  address width
//  DW          64  data width (one `WORD)
//  TIMEOUT     16  ACCESS cycles without mem_ack before abort (>=2)
//  STARVE_MAX   4  consecutive data wins allowed while if_req pending (>=1)
// PORTS
//  clk        in   1   rising-edge clock; the only clock
//  rst        in   1   reset, asynchronous, active-high
//  if_req     in   1   fetch request; held high, addr stable, until if_done
//  if_addr    in   AW  fetch address
//  if_rdata   out  DW  fetch read data, valid while if_done=1
//  if_done    out  1   one-cycle completion pulse to fetch
//  d_req      in   1   data request; held high, fields stable, until d_done
//  d_we       in   1   1=write, 0=read
//  d_addr     in   AW  data address
//  d_wdata    in   DW  write data
//  d_rdata    out  DW  data read data, valid while d_done=1
//  d_done     out  1   one-cycle completion pulse to data side
//  mem_en     out  1   memory access strobe; held until mem_ack or timeout
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, sampled with mem_ack
//  mem_ack    in   1   memory completion; meaningful only while mem_en=1
//  busy       out  1   1 when state != IDLE
//  err        out  1   sticky timeout flag; cleared only by rst
// BEHAVIOUR
//  - Output registers: every output is registered.
//  - Reset values: all outputs are 0 on rst, as are the owner register, timeout counter and starve counter.
//  - Reset mid-operation: asserting rst in any state drops mem_en at once (async clear) and returns the FSM to IDLE.
//    No done pulse is issued for an access aborted by reset.
//  - FSM state IDLE:
//    - If no request is pending, stay in IDLE.
//    - Otherwise pick an owner. Data wins, except that fetch wins when starve_cnt == STARVE_MAX.
//    - At the grant edge, latch the owner, mem_addr and mem_we (d_we for data, 0 for fetch); also latch mem_wdata for data.
//    - Set mem_en=1, clear the timeout counter, go to ACCESS.
//  - Starve counter:
//    - Increments when data wins while if_req=1.
//    - Resets to 0 when fetch is granted, or when if_req=0 in IDLE.
//    - Saturates at STARVE_MAX.
//  - FSM state ACCESS:
//    - mem_en=1 and all mem_* outputs held stable.
//    - On mem_ack=1: mem_en->0. On a read, copy mem_rdata into the owner's rdata register. Pulse the owner's done. Go to DONE.
//    - A write leaves d_rdata unchanged.
//    - Otherwise the timeout counter increments. At count TIMEOUT-1 with no ack: mem_en->0, err->1, owner done pulses, owner rdata->0, go to DONE.
//    - A mem_ack arriving in the same cycle as the timeout wins: no err.
//  - FSM state DONE:
//    - The done pulse is visible this cycle.
//    - Requests are not sampled in DONE, so a stale held req is never re-issued.
//    - The requester drops or updates req at the next edge. Next state is IDLE.
//  - Latency: minimum 3 cycles per access (grant, ack in first ACCESS cycle, DONE).
//    - Back-to-back throughput is 1 access per 3 cycles.
//  - done pulses: exactly one per granted access. if_done and d_done are never high together.
//  - A requester dropping req while in ACCESS is illegal. The arbiter completes the access regardless.
//  - mem_ack while mem_en=0 is ignored.
// TESTING
//  1. Fetch only: if_req=1, if_addr=0x40; mem_ack one cycle after mem_en with mem_rdata=0x30F4_0000_0000_0010
//     -> mem_en high 1 cycle, if_rdata=0x30F4_0000_0000_0010, if_done for 1 cycle, busy=0 on the following cycle.
//  2. Write then read:
//     d_we=1, d_addr=0x100, d_wdata=0xDEAD -> mem_we=1, mem_wdata=0xDEAD, d_done, d_rdata unchanged.
//     Then d_we=0, mem_rdata=0xDEAD -> d_rdata=0xDEAD.
//  3. Contention: if_req and d_req held high continuously, immediate acks.
//     -> grant order D,D,D,D,F,D,D,D,D,F; no fetch wait exceeds 4 data accesses.
//  4. Timeout: d_req=1, mem_ack never asserted
//     -> mem_en drops after 16 ACCESS cycles, d_done=1, d_rdata=0, err=1 and sticky.
//     A subsequent fetch still completes normally.
//  5. Reset mid-access: assert rst during ACCESS at a non-edge time
//     -> mem_en, busy, if_done and d_done are 0 immediately; err=0; after release, idle until a new req.
//  6. Late ack: mem_ack asserted on the 16th ACCESS cycle -> normal completion, err stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Unified memory-port arbiter for the Y86 fetch and data requesters.
// Each access runs IDLE -> ACCESS -> DONE with registered outputs, fetch anti-starvation and an ack timeout.
module mem_port_arbiter #(
    parameter int AW         = 64,
    parameter int DW         = 64,
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          busy,
    output logic          err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    localparam int TW = $clog2(TIMEOUT);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [1:0]    state;
    logic          owner;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] starve_cnt;
    logic          grant_fetch;
    logic          starve_hit;

    assign starve_hit  = (starve_cnt == SW'(STARVE_MAX));
    // Data normally wins; a pending fetch takes the port once data has won STARVE_MAX times in a row.
    assign grant_fetch = if_req && (!d_req || starve_hit);

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= OWN_FETCH;
            tcnt       <= '0;
            starve_cnt <= '0;
            if_rdata   <= '0;
            if_done    <= 1'b0;
            d_rdata    <= '0;
            d_done     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!if_req) starve_cnt <= '0;
                    if (if_req || d_req) begin
                        if (grant_fetch) begin
                            owner      <= OWN_FETCH;
                            mem_addr   <= if_addr;
                            mem_we     <= 1'b0;
                            starve_cnt <= '0;
                        end else begin
                            owner     <= OWN_DATA;
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                            if (if_req && !starve_hit) starve_cnt <= starve_cnt + 1'b1;
                        end
                        mem_en <= 1'b1;
                        tcnt   <= '0;
                        busy   <= 1'b1;
                        state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        mem_en <= 1'b0;
                        if (!mem_we) begin
                            if (owner == OWN_DATA) d_rdata  <= mem_rdata;
                            else                   if_rdata <= mem_rdata;
                        end
                        if (owner == OWN_DATA) d_done  <= 1'b1;
                        else                   if_done <= 1'b1;
                        state <= S_DONE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        // Abort: the owner still gets its done pulse, with zeroed read data.
                        mem_en <= 1'b0;
                        err    <= 1'b1;
                        if (owner == OWN_DATA) begin
                            d_rdata <= '0;
                            d_done  <= 1'b1;
                        end else begin
                            if_rdata <= '0;
                            if_done  <= 1'b1;
                        end
                        state <= S_DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    mem_en <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory responder with programmable ack delay,
// expected completions queued at stimulus time and compared when a done pulse appears.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic [63:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_done;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        err;

    typedef struct {
        bit          is_data;
        logic [63:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mem_model [logic [63:0]];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          ack_delay = 0;
    bit          ack_never = 0;

    localparam logic [63:0] FETCH_VAL = 64'h30F4_0000_0000_0010;
    localparam logic [63:0] A_VAL     = 64'h1111_2222_3333_4444;
    localparam logic [63:0] B_VAL     = 64'h5555_6666_7777_8888;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ack on the (ack_delay+1)-th cycle that mem_en is seen high.
    initial begin
        int en_cnt;
        en_cnt    = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_en && !rst) begin
                if (!ack_never && en_cnt == ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 64'h0;
                end else begin
                    mem_ack = 1'b0;
                end
                en_cnt++;
            end else begin
                mem_ack = 1'b0;
                en_cnt  = 0;
            end
        end
    end

    // Completion monitor: pops the scoreboard on each done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_done && d_done) begin
                total_cnt++;
                $display("FAIL both_done: if_done=%0b d_done=%0b, required not both", if_done, d_done);
            end else if (if_done || d_done) begin
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_done: if_done=%0b d_done=%0b with empty scoreboard", if_done, d_done);
                end else begin
                    pass_cnt++;
                    e = sb.pop_front();
                    total_cnt++;
                    if (d_done !== e.is_data)
                        $display("FAIL done_owner: got data=%0b, required data=%0b", d_done, e.is_data);
                    else pass_cnt++;
                    total_cnt++;
                    if ((d_done ? d_rdata : if_rdata) !== e.rdata)
                        $display("FAIL done_rdata: got %h, required %h", d_done ? d_rdata : if_rdata, e.rdata);
                    else pass_cnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_done(input int budget, output int en_cycles, output bit timed_out);
        int i;
        en_cycles = 0;
        timed_out = 1'b1;
        i = 0;
        while (timed_out && i < budget) begin
            @(negedge clk);
            if (mem_en) en_cycles++;
            if (if_done || d_done) timed_out = 1'b0;
            i++;
        end
        total_cnt++;
        if (timed_out) $display("FAIL done_wait: no done within %0d cycles", budget);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({mem_en, busy, err, if_done, d_done, mem_we} !== 6'b0)
            $display("FAIL reset_ctrl: got %b, required 000000", {mem_en, busy, err, if_done, d_done, mem_we});
        else pass_cnt++;
        total_cnt++;
        if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 256'h0)
            $display("FAIL reset_data: got %h, required 0", {if_rdata, d_rdata, mem_addr, mem_wdata});
        else pass_cnt++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%0b, required 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_fetch_only;
        int n;
        bit to;
        mem_model[64'h40] = FETCH_VAL;
        sb.push_back('{1'b0, FETCH_VAL});
        if_req  = 1'b1;
        if_addr = 64'h40;
        @(negedge clk);
        total_cnt++;
        if ({mem_en, mem_we, busy} !== 3'b101 || mem_addr !== 64'h40)
            $display("FAIL fetch_grant: en/we/busy=%b addr=%h, required 101 addr=40", {mem_en, mem_we, busy}, mem_addr);
        else pass_cnt++;
        wait_done(8, n, to);
        total_cnt++;
        if (1 + n !== 1) $display("FAIL fetch_en_len: got %0d cycles, required 1", 1 + n);
        else pass_cnt++;
        if_req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({busy, if_done} !== 2'b00) $display("FAIL fetch_after: busy/if_done=%b, required 00", {busy, if_done});
        else pass_cnt++;
    endtask

    task automatic test_write_read;
        int n;
        bit to;
        sb.push_back('{1'b1, 64'h0});
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 64'h100;
        d_wdata = 64'hDEAD;
        @(negedge clk);
        total_cnt++;
        if (mem_we !== 1'b1 || mem_wdata !== 64'hDEAD || mem_addr !== 64'h100)
            $display("FAIL write_fields: we=%0b wdata=%h addr=%h, required 1 dead 100", mem_we, mem_wdata, mem_addr);
        else pass_cnt++;
        wait_done(8, n, to);
        sb.push_back('{1'b1, 64'hDEAD});
        d_we = 1'b0;
        wait_done(10, n, to);
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention;
        int n;
        bit to;
        mem_model[64'h200] = A_VAL;
        mem_model[64'h300] = B_VAL;
        for (int k = 0; k < 10; k++) sb.push_back('{(k % 5) != 4, ((k % 5) != 4) ? B_VAL : A_VAL});
        if_addr = 64'h200;
        d_addr  = 64'h300;
        d_we    = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        for (int k = 0; k < 10; k++) wait_done(10, n, to);
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (sb.size() != 0) $display("FAIL contention_drain: %0d pending, required 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_timeout;
        int n;
        bit to;
        ack_never = 1'b1;
        sb.push_back('{1'b1, 64'h0});
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 64'h500;
        wait_done(40, n, to);
        total_cnt++;
        if (n !== 16) $display("FAIL timeout_len: mem_en high %0d cycles, required 16", n);
        else pass_cnt++;
        total_cnt++;
        if ({err, mem_en} !== 2'b10) $display("FAIL timeout_err: err/mem_en=%b, required 10", {err, mem_en});
        else pass_cnt++;
        d_req     = 1'b0;
        ack_never = 1'b0;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (err !== 1'b1) $display("FAIL err_sticky: err=%0b, required 1", err);
        else pass_cnt++;
        sb.push_back('{1'b0, A_VAL});
        if_req  = 1'b1;
        if_addr = 64'h200;
        wait_done(10, n, to);
        if_req = 1'b0;
        total_cnt++;
        if (n !== 1) $display("FAIL fetch_after_timeout: mem_en high %0d cycles, required 1", n);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access;
        ack_never = 1'b1;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 64'h300;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (mem_en !== 1'b1) $display("FAIL pre_reset_access: mem_en=%0b, required 1", mem_en);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({mem_en, busy, if_done, d_done, err} !== 5'b0)
            $display("FAIL async_reset: en/busy/ifd/dd/err=%b, required 00000", {mem_en, busy, if_done, d_done, err});
        else pass_cnt++;
        d_req     = 1'b0;
        ack_never = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({mem_en, busy} !== 2'b00) $display("FAIL idle_after_rst: en/busy=%b, required 00", {mem_en, busy});
            else pass_cnt++;
        end
    endtask

    task automatic test_late_ack;
        int n;
        bit to;
        ack_delay = 15;
        sb.push_back('{1'b1, B_VAL});
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 64'h300;
        wait_done(40, n, to);
        d_req = 1'b0;
        total_cnt++;
        if (n !== 16) $display("FAIL late_ack_len: mem_en high %0d cycles, required 16", n);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL late_ack_err: err=%0b, required 0", err);
        else pass_cnt++;
        ack_delay = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        test_reset;
        test_fetch_only;
        test_write_read;
        test_contention;
        test_timeout;
        test_reset_mid_access;
        test_late_ack;
        total_cnt++;
        if (sb.size() != 0) $display("FAIL final_drain: %0d pending, required 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
